// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between a host and uart_tx_fifo.
// master (host): drives DataToTransmit, Transmit, ClearInterrupt; observes
//   SerialOutputTx, Busy, FifoFull, FifoEmpty, TxInterrupt, Overflow.
// slave (transmitter): the mirror image of master.
interface uart_tx_fifo_if;
  logic [7:0] DataToTransmit;
  logic       Transmit;
  logic       ClearInterrupt;
  logic       SerialOutputTx;
  logic       Busy;
  logic       FifoFull;
  logic       FifoEmpty;
  logic       TxInterrupt;
  logic       Overflow;

  modport master (
    output DataToTransmit, Transmit, ClearInterrupt,
    input  SerialOutputTx, Busy, FifoFull, FifoEmpty, TxInterrupt, Overflow
  );

  modport slave (
    input  DataToTransmit, Transmit, ClearInterrupt,
    output SerialOutputTx, Busy, FifoFull, FifoEmpty, TxInterrupt, Overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes are queued in a small FIFO and sent as
// start, 8 data bits LSB first, parity, stop. Back-to-back frames are gap-free.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low
//   bus    - uart_tx_fifo_if.slave: byte write strobe/data, interrupt clear,
//            serial line, Busy, FIFO full/empty, sticky TxInterrupt/Overflow
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_parity;
  logic               r_tx;
  logic               r_busy;
  logic               r_full;
  logic               r_empty;
  logic               r_irq;
  logic               r_ovf;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  state_t             w_state_next;
  logic [2:0]         w_bit_idx_next;
  logic [7:0]         w_shift_next;
  logic               w_parity_next;
  logic               w_tx_next;
  logic               w_pop;
  logic               w_irq_set;
  logic               w_bit_end;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_wr_en;
  logic               w_ovf_set;
  logic [7:0]         w_head;
  logic [CNT_W-1:0]   w_count_next;
  logic [BAUD_W-1:0]  w_baud_next;

  assign w_bit_end    = (r_baud == BAUD_LAST);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == DEPTH_C);
  assign w_head       = r_mem[r_rd_ptr];

  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign w_wr_en   = bus.Transmit && (!w_fifo_full || w_pop);
  assign w_ovf_set = bus.Transmit && w_fifo_full && !w_pop;

  // Next-state, FIFO pop and next serial-line value.
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_pop          = 1'b0;
    w_irq_set      = 1'b0;
    w_tx_next      = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = w_head;
          w_parity_next = (^w_head) ^ PARITY_ODD;
          w_state_next  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bit_idx_next = 3'd0;
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_PARITY;
          end else begin
            w_bit_idx_next = 3'(r_bit_idx + 3'd1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_fifo_empty) begin
            w_pop         = 1'b1;
            w_shift_next  = w_head;
            w_parity_next = (^w_head) ^ PARITY_ODD;
            w_state_next  = S_START;
          end else begin
            w_irq_set    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Line value is chosen from the state being entered so it is a clean flop.
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_parity_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

  // FIFO occupancy and baud counter next values.
  always_comb begin
    w_count_next = r_count;
    if (w_wr_en && !w_pop) begin
      w_count_next = CNT_W'(r_count + 1'b1);
    end else if (!w_wr_en && w_pop) begin
      w_count_next = CNT_W'(r_count - 1'b1);
    end

    w_baud_next = BAUD_W'(r_baud + 1'b1);
    if ((r_state == S_IDLE) || (w_state_next != r_state) || w_bit_end) begin
      w_baud_next = '0;
    end
  end

  // FSM, datapath, FIFO control and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_irq     <= 1'b0;
      r_ovf     <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != S_IDLE);
      r_full    <= (w_count_next == DEPTH_C);
      r_empty   <= (w_count_next == '0);
      r_count   <= w_count_next;
      if (w_wr_en) begin
        r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      end
      // Set events take priority over a simultaneous clear.
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (bus.ClearInterrupt) begin
        r_irq <= 1'b0;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (bus.ClearInterrupt) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= bus.DataToTransmit;
    end
  end

  assign bus.SerialOutputTx = r_tx;
  assign bus.Busy           = r_busy;
  assign bus.FifoFull       = r_full;
  assign bus.FifoEmpty      = r_empty;
  assign bus.TxInterrupt    = r_irq;
  assign bus.Overflow       = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame decoder pops expected bytes from a queue
// filled as bytes are written, plus directed status and timing checks.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam bit          PODD  = 1'b0;

  logic clk;
  logic reset;
  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .PARITY_ODD   (PODD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [7:0]  exp_q [$];
  int unsigned wr_edge;
  int unsigned last_gap;
  int unsigned last_start_cyc;
  logic        last_irq_start;
  logic        last_irq_end;
  logic        last_empty_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Writes one byte; sampled at the next rising edge. Call at #1 after an edge.
  task automatic send(input logic [7:0] b, input bit will_tx);
    bus.DataToTransmit = b;
    bus.Transmit       = 1'b1;
    @(posedge clk);
    #1;
    wr_edge      = cyc;
    bus.Transmit = 1'b0;
    if (will_tx) exp_q.push_back(b);
  endtask

  task automatic clear_flags();
    bus.ClearInterrupt = 1'b1;
    sync();
    bus.ClearInterrupt = 1'b0;
  endtask

  // Decodes one frame sampling on falling edges and scores it against the queue.
  task automatic receive_frame();
    logic [10:0] bits;
    logic        stable;
    logic [7:0]  exp;
    last_gap = 0;
    @(negedge clk);
    while (bus.SerialOutputTx !== 1'b0) begin
      last_gap++;
      if (last_gap > 300) begin
        check("start_timeout", 32'(last_gap), 32'd0);
        return;
      end
      @(negedge clk);
    end
    last_start_cyc   = cyc;
    last_irq_start   = bus.TxInterrupt;
    last_empty_start = bus.FifoEmpty;
    stable = 1'b1;
    bits   = '0;
    for (int b = 0; b < 11; b++) begin
      for (int s = 0; s < int'(CPB); s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        if (s == 0) bits[b] = bus.SerialOutputTx;
        else if (bus.SerialOutputTx !== bits[b]) stable = 1'b0;
      end
    end
    last_irq_end = bus.TxInterrupt;
    check("bit_width", 32'(stable), 32'd1);
    check("start_bit", 32'(bits[0]), 32'd0);
    check("stop_bit", 32'(bits[10]), 32'd1);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'(bits[8:1]), 32'hFFFF_FFFF);
    end else begin
      exp = exp_q.pop_front();
      check("data", 32'(bits[8:1]), 32'(exp));
      check("parity", 32'(bits[9]), 32'((^exp) ^ PODD));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned gaps [3];
    logic        irqs [3];
    logic        irq_ends [3];
    logic        empties [3];
    int unsigned lows;
    int unsigned w0;

    n_checks = 0;
    n_fail   = 0;
    bus.DataToTransmit = 8'h00;
    bus.Transmit       = 1'b0;
    bus.ClearInterrupt = 1'b0;
    reset = 1'b0;
    repeat (3) sync();

    // Reset state
    check("rst_line", 32'(bus.SerialOutputTx), 32'd1);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_full", 32'(bus.FifoFull), 32'd0);
    check("rst_empty", 32'(bus.FifoEmpty), 32'd1);
    check("rst_irq", 32'(bus.TxInterrupt), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);
    reset = 1'b1;
    repeat (2) sync();

    // Single frame 0x55: latency and 44-cycle frame
    fork
      send(8'h55, 1'b1);
      receive_frame();
    join
    check("t1_latency", last_start_cyc, wr_edge + 1);
    check("t1_irq_before_end", 32'(last_irq_end), 32'd0);
    @(negedge clk);
    check("t1_irq", 32'(bus.TxInterrupt), 32'd1);
    check("t1_busy", 32'(bus.Busy), 32'd0);
    check("t1_line_idle", 32'(bus.SerialOutputTx), 32'd1);
    sync();
    clear_flags();
    check("t1_irq_cleared", 32'(bus.TxInterrupt), 32'd0);

    // 0xA7: even parity bit must be 1
    fork
      send(8'hA7, 1'b1);
      receive_frame();
    join
    sync();
    clear_flags();

    // Three back-to-back frames with no idle gap
    fork
      begin
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          receive_frame();
          gaps[i]     = last_gap;
          irqs[i]     = last_irq_start;
          irq_ends[i] = last_irq_end;
          empties[i]  = last_empty_start;
        end
      end
    join
    check("t3_gap2", gaps[1], 32'd0);
    check("t3_gap3", gaps[2], 32'd0);
    check("t3_irq_f2", 32'(irqs[1]), 32'd0);
    check("t3_irq_f3", 32'(irqs[2]), 32'd0);
    check("t3_irq_end_f2", 32'(irq_ends[1]), 32'd0);
    check("t3_empty_f2", 32'(empties[1]), 32'd0);
    check("t3_empty_f3", 32'(empties[2]), 32'd1);
    @(negedge clk);
    check("t3_irq_done", 32'(bus.TxInterrupt), 32'd1);
    sync();
    clear_flags();

    // Fill while busy, then overflow; 0xFF must never appear
    fork
      begin
        send(8'h10, 1'b1);
        send(8'h11, 1'b1);
        send(8'h12, 1'b1);
        send(8'h13, 1'b1);
        send(8'h14, 1'b1);
        check("t4_full", 32'(bus.FifoFull), 32'd1);
        check("t4_no_ovf_yet", 32'(bus.Overflow), 32'd0);
        send(8'hFF, 1'b0);
        check("t4_ovf", 32'(bus.Overflow), 32'd1);
        check("t4_still_full", 32'(bus.FifoFull), 32'd1);
        clear_flags();
        check("t4_ovf_cleared", 32'(bus.Overflow), 32'd0);
      end
      begin
        for (int i = 0; i < 5; i++) receive_frame();
      end
    join
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);
    sync();

    // Reset during DATA of 0x00 aborts the frame and drops the queue
    check("t5_irq_pre", 32'(bus.TxInterrupt), 32'd1);
    send(8'h00, 1'b0);
    send(8'h33, 1'b0);
    repeat (12) sync();
    check("t5_line_data", 32'(bus.SerialOutputTx), 32'd0);
    check("t5_busy_pre", 32'(bus.Busy), 32'd1);
    reset = 1'b0;
    sync();
    reset = 1'b1;
    check("t5_line", 32'(bus.SerialOutputTx), 32'd1);
    check("t5_busy", 32'(bus.Busy), 32'd0);
    check("t5_empty", 32'(bus.FifoEmpty), 32'd1);
    check("t5_full", 32'(bus.FifoFull), 32'd0);
    check("t5_irq", 32'(bus.TxInterrupt), 32'd0);
    check("t5_ovf", 32'(bus.Overflow), 32'd0);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.SerialOutputTx !== 1'b1) lows++;
    end
    check("t5_no_frame", lows, 32'd0);
    sync();

    // Write while full coinciding with the stop-end pop
    fork
      begin
        send(8'h20, 1'b1);
        w0 = wr_edge;
        send(8'h21, 1'b1);
        send(8'h22, 1'b1);
        send(8'h23, 1'b1);
        send(8'h24, 1'b1);
        while (cyc < w0 + 44) sync();
        check("t6_full_before", 32'(bus.FifoFull), 32'd1);
        send(8'h25, 1'b1);
        check("t6_full_after", 32'(bus.FifoFull), 32'd1);
        check("t6_no_ovf", 32'(bus.Overflow), 32'd0);
      end
      begin
        for (int i = 0; i < 6; i++) receive_frame();
      end
    join
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    check("t6_ovf_end", 32'(bus.Overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter, the outgoing counterpart to the team's parity-checking UART receiver. It accepts bytes into a small FIFO and serialises each one as a frame: start bit, 8 data bits LSB first, parity bit, stop bit. It raises a sticky completion interrupt when the line goes idle, and reports FIFO overflow. It sits between the processor or register interface and the serial TX pin, and produces frames the existing receiver decodes without parity error.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal minimum 2.
FIFO_DEPTH, 4, number of byte entries; must be a power of 2, minimum 2.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity.

Ports:
clk  input  1  single system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
DataToTransmit  input  8  byte written into the FIFO when Transmit=1.
Transmit  input  1  write strobe, active-high, one byte per cycle high.
ClearInterrupt  input  1  synchronous clear of TxInterrupt and Overflow.
SerialOutputTx  output  1  serial line, idle high, registered.
Busy  output  1  1 whenever the FSM is not in IDLE.
FifoFull  output  1  FIFO holds FIFO_DEPTH entries.
FifoEmpty  output  1  FIFO holds 0 entries.
TxInterrupt  output  1  sticky; set when the last queued frame's stop bit completes.
Overflow  output  1  sticky; set when a write is attempted while the FIFO is full.

Behaviour:
- Reset (reset=0 at a rising edge):
  - SerialOutputTx=1, Busy=0, FifoFull=0, FifoEmpty=1, TxInterrupt=0, Overflow=0.
  - FIFO pointers and count zeroed; FSM to IDLE; baud counter and bit index zeroed.
  - Reset asserted mid-frame aborts the frame; the line is high from the next edge.
- FIFO: circular buffer with read/write pointers and a count of log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
  - Write when Transmit=1 and not full.
  - Write while full: data dropped, Overflow set.
  - Pop and write in the same cycle while full: both happen; count unchanged; no overflow.
  - Pop and write in the same cycle while empty: not possible, because the FSM only pops when FifoEmpty=0 at that edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line=1. If FifoEmpty=0, pop the head byte into the shift register, compute parity = XOR(byte) ^ PARITY_ODD, go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; after bit index 7, go to PARITY.
  - PARITY: line=parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles. At the end of the bit:
    - if the FIFO is non-empty, pop and go directly to START (gap-free back-to-back frames);
    - otherwise go to IDLE and set TxInterrupt.
- Baud counter: counts 0..CLKS_PER_BIT-1; reloads to 0 on every state entry.
- Latency: Transmit sampled at edge k with the FSM idle and the FIFO empty → FIFO non-empty after edge k → pop at edge k+1 → SerialOutputTx=0 from edge k+1 onward.
- Frame length: exactly 11*CLKS_PER_BIT cycles.
- SerialOutputTx is driven from a flop, so it has no glitches.
- Interrupt flags: ClearInterrupt=1 zeroes both flags. A simultaneous set event wins over ClearInterrupt, so no event is lost.
- Data written during a frame is queued and never disturbs the frame in flight.

Test Plan:
1. CLKS_PER_BIT=4; reset, then write 0x55 → line low 1 cycle after the write edge; frame bits 0,1,0,1,0,1,0,1,0,0(parity),1, each 4 cycles; TxInterrupt=1 after 44 cycles; Busy=0.
2. Write 0xA7 with PARITY_ODD=0 → data bits 1,1,1,0,0,1,0,1; parity bit 1; stop 1; the existing receiver decodes 0xA7 with ParityError=0.
3. Write 0x01,0x02,0x03 on consecutive cycles → three frames, 132 cycles total, no idle-high gap between the stop bit and the next start bit; FifoEmpty=1 after the third pop; TxInterrupt set once, at the end of the third frame.
4. Fill 4 entries while busy, then write 0xFF → FifoFull=1, Overflow=1, 0xFF never transmitted; ClearInterrupt pulse → Overflow=0.
5. Assert reset=0 for one cycle during the DATA state of 0x00 → SerialOutputTx=1 on the next edge; FifoEmpty=1; no further frame; all flags 0.
6. With the FIFO full, write in the same cycle as the STOP-end pop → write accepted; count stays 4; Overflow=0; the new byte is transmitted last.
